// File: rtl/lpm_pkg.sv
// Shared LPM definitions: payload width, rule count, entry layout and the
// traversal-counter marking applied to every request the responder accepts.
package lpm_pkg;

    localparam int LPM_DATA_W = 704;
    localparam int lpm_mem_responder_RULE_COUNT = 1;
    localparam int LPM_CNT_W = 8;

    typedef struct packed {
        logic [LPM_DATA_W-1:0] data;
        logic [LPM_CNT_W-1:0]  cnt;
    } lpm_mem_entry_t;

    // Upper payload passes through; the low word counts memory traversals.
    function automatic logic [LPM_DATA_W-1:0] mark(input logic [LPM_DATA_W-1:0] v);
        return {v[LPM_DATA_W-1:32], v[31:0] + 32'd1};
    endfunction

endpackage

// File: rtl/lpm_mem_slot.sv
// One responder entry: payload register plus a memory-delay countdown that
// loads LATENCY on acceptance and steps down on each memdelay firing.
module lpm_mem_slot #(
    parameter int DATA_W  = 704,
    parameter int CNT_W   = 2,
    parameter int LATENCY = 3
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              dec,
    output logic [DATA_W-1:0] data,
    output logic              zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(LATENCY);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Payload is deliberately not reset; occupancy lives in the top's pointers.
    always_ff @(posedge CLK) begin
        if (nRST && load) begin
            data <= load_data;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lpm_mem_responder.sv
// Responder end of the LPM memory protocol: in-order circular buffer of
// requests, each released once it has seen LATENCY memdelay firings.
module lpm_mem_responder
    import lpm_pkg::*;
#(
    parameter int DATA_W  = LPM_DATA_W,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 3
) (
    input  logic                                  CLK,
    input  logic                                  nRST,
    input  logic                                  req__ENA,
    input  logic [DATA_W-1:0]                     req_v,
    output logic                                  req__RDY,
    input  logic                                  resAccept__ENA,
    output logic                                  resAccept__RDY,
    output logic [DATA_W-1:0]                     resValue,
    output logic                                  resValue__RDY,
    input  logic [lpm_mem_responder_RULE_COUNT:0] rule_enable,
    output logic [lpm_mem_responder_RULE_COUNT:0] rule_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       count;
    logic [DEPTH-1:0]  occ;
    logic [DEPTH-1:0]  zero;
    logic [DATA_W-1:0] slot_data [DEPTH];
    logic [DATA_W-1:0] marked;
    logic              req_fire;
    logic              acc_fire;
    logic              md_fire;
    logic              unused_rule_enable;

    // DATA_W is expected not to exceed LPM_DATA_W; mark() works on the shared width.
    assign marked = DATA_W'(mark(LPM_DATA_W'(req_v)));

    // Ready/valid: an ENA counts only in a cycle where its RDY is high, and every
    // RDY is a function of registered state alone, never of a same-cycle ENA.
    assign req__RDY       = (count != FULL);
    assign resAccept__RDY = (count != '0) && zero[head];
    assign resValue__RDY  = resAccept__RDY;
    assign resValue       = slot_data[head];

    assign rule_ready[0] = |(occ & ~zero);
    assign rule_ready[lpm_mem_responder_RULE_COUNT:1] = '0;
    assign unused_rule_enable = ^rule_enable[lpm_mem_responder_RULE_COUNT:1];

    assign req_fire = req__ENA && req__RDY;
    assign acc_fire = resAccept__ENA && resAccept__RDY;
    assign md_fire  = rule_enable[0] && rule_ready[0];

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = ({1'b0, AW'(i) - head} < count);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        lpm_mem_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CW),
            .LATENCY(LATENCY)
        ) u_slot (
            .CLK      (CLK),
            .nRST     (nRST),
            .load     (req_fire && (tail == AW'(g))),
            .load_data(marked),
            .dec      (md_fire && occ[g]),
            .data     (slot_data[g]),
            .zero     (zero[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (req_fire) begin
                tail <= tail + 1'b1;
            end
            if (acc_fire) begin
                head <= head + 1'b1;
            end
            case ({req_fire, acc_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
